multicycle_control: RTL

Main control FSM of the multicycle RV32I core. It sequences the fetch/decode/execute/memory/writeback steps and drives the instruction-register load strobe, the PC write strobe and all datapath mux selects. It waits on a memory-ready handshake and counts retired instructions. On an unsupported opcode it parks in a trap state.

---
 rtl/multicycle_control.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback, drives the instruction
// register and PC strobes plus every datapath mux select, waits on the
// memory-ready handshake and counts retired instructions. Unsupported
// opcodes park the machine in TRAP until reset.
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             op,
  input  logic [2:0]             func3,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   IRWrite,
  output logic                   PCWrite,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   RegWrite,
  output logic                   AdrSrc,
  output logic [1:0]             ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [1:0]             ResultSrc,
  output logic [2:0]             ImmSrc,
  output logic                   illegal,
  output logic [3:0]             state,
  output logic [COUNT_WIDTH-1:0] retire_count
);

  // State encodings (visible on the debug port)
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd15;

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Mux select encodings
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_FUNC    = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_RDATA   = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;
  localparam logic [1:0] RES_IMM     = 2'b11;

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [3:0]             state_reg;
  logic [3:0]             state_next;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   retire;

  // Only beq and bne are implemented; other branch flavours trap.
  logic branch_supported;
  assign branch_supported = (func3 == 3'b000) || (func3 == 3'b001);

  // State register: reset returns to FETCH regardless of other inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; memory states hold until mem_ready
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD,
          OP_STORE:  state_next = S_MEMADR;
          OP_RTYPE:  state_next = S_EXECR;
          OP_ITYPE:  state_next = S_EXECI;
          OP_BRANCH: state_next = branch_supported ? S_BRANCH : S_TRAP;
          OP_JAL:    state_next = S_JAL;
          OP_LUI:    state_next = S_LUI;
          default:   state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_next = S_ALUWB;   // JAL writes OldPC+4 in ALUWB
      S_MEMWB,
      S_ALUWB,
      S_BRANCH,
      S_LUI:      state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_TRAP;    // unused encodings are treated as faults
    endcase
  end

  // Output decode: Moore per state, plus the mem_ready/zero gated PC and IR strobes
  always_comb begin
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALU_ADD;
    ResultSrc = RES_ALUOUT;
    illegal   = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          MemRead   = 1'b1;
          AdrSrc    = 1'b0;
          ALUSrcA   = SRCA_PC;
          ALUSrcB   = SRCB_FOUR;
          ALUOp     = ALU_ADD;
          ResultSrc = RES_ALURES;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_ADD;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_ADD;
        end
        S_MEMREAD: begin
          MemRead   = 1'b1;
          AdrSrc    = 1'b1;
          ResultSrc = RES_ALUOUT;
        end
        S_MEMWB: begin
          RegWrite  = 1'b1;
          ResultSrc = RES_RDATA;
        end
        S_MEMWRITE: begin
          MemWrite  = 1'b1;
          AdrSrc    = 1'b1;
          ResultSrc = RES_ALUOUT;
        end
        S_EXECR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_RS2;
          ALUOp   = ALU_FUNC;
        end
        S_EXECI: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_FUNC;
        end
        S_ALUWB: begin
          RegWrite  = 1'b1;
          ResultSrc = RES_ALUOUT;
        end
        S_JAL: begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          ALUOp     = ALU_ADD;
          ResultSrc = RES_ALUOUT;
          PCWrite   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA   = SRCA_RS1;
          ALUSrcB   = SRCB_RS2;
          ALUOp     = ALU_SUB;
          ResultSrc = RES_ALUOUT;
          case (func3)
            3'b000:  PCWrite = zero;
            3'b001:  PCWrite = ~zero;
            default: PCWrite = 1'b0;
          endcase
        end
        S_LUI: begin
          RegWrite  = 1'b1;
          ResultSrc = RES_IMM;
        end
        S_TRAP: begin
          illegal = 1'b1;
        end
        default: begin
          illegal = 1'b0;
        end
      endcase
    end
  end

  // Immediate format follows the opcode directly, independent of state
  always_comb begin
    ImmSrc = 3'b000;
    if (!reset) begin
      case (op)
        OP_STORE:  ImmSrc = 3'b001;
        OP_BRANCH: ImmSrc = 3'b010;
        OP_JAL:    ImmSrc = 3'b011;
        OP_LUI:    ImmSrc = 3'b100;
        default:   ImmSrc = 3'b000;
      endcase
    end
  end

  // An instruction retires in its final state (store only once memory accepts it)
  always_comb begin
    retire = 1'b0;
    case (state_reg)
      S_MEMWB,
      S_ALUWB,
      S_BRANCH,
      S_LUI:      retire = 1'b1;
      S_MEMWRITE: retire = mem_ready;
      default:    retire = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps naturally at its width
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (retire) begin
      count_reg <= count_reg + COUNT_ONE;
    end
  end

  assign state        = state_reg;
  assign retire_count = count_reg;

endmodule
